// File: rtl/shift_sequencer.sv
// Multi-cycle variable shifter (SLL/SRL/SRA, 0..2^SHAMT_W-1) built from a
// shift-by-2 stage stepped once per cycle plus a final shift-by-1 for odd amounts.
module shift_sequencer #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   operand,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  function automatic logic [WIDTH-1:0] f_shift(
    input logic [WIDTH-1:0] a,
    input logic [1:0]       kind,
    input logic [1:0]       amt
  );
    logic signed [WIDTH-1:0] s;
    logic        [WIDTH-1:0] r;
    s = a;
    case (kind)
      OP_SLL:  r = a << amt;
      OP_SRL:  r = a >> amt;
      OP_SRA:  r = $unsigned(s >>> amt);
      default: r = a;
    endcase
    return r;
  endfunction

  state_t             r_state;
  logic [WIDTH-1:0]   r_acc;
  logic [SHAMT_W-1:0] r_cnt;
  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_result;
  logic               r_busy;
  logic               r_done;

  logic [1:0]         w_amt;
  logic [SHAMT_W-1:0] w_cnt_next;
  logic [WIDTH-1:0]   w_acc_next;

  // Step size for this cycle: 2 while at least two remain, then 1 for the odd tail.
  always_comb begin
    w_amt = 2'd0;
    if (r_cnt >= SHAMT_W'(2)) begin
      w_amt = 2'd2;
    end else if (r_cnt == SHAMT_W'(1)) begin
      w_amt = 2'd1;
    end
  end

  assign w_cnt_next = r_cnt - SHAMT_W'(w_amt);
  assign w_acc_next = f_shift(r_acc, r_op, w_amt);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_op     <= OP_SLL;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_acc   <= operand;
            r_op    <= op;
            // The reserved opcode passes the operand through unchanged.
            r_cnt   <= (op == OP_RSV) ? '0 : shamt;
            r_busy  <= 1'b1;
            r_state <= S_SHIFT;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          r_acc <= w_acc_next;
          r_cnt <= w_cnt_next;
          if (w_cnt_next == '0) begin
            r_result <= w_acc_next;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Multi-cycle variable-shift controller for the integer datapath. It executes SLL, SRL and SRA by any amount from 0 to 31. It steps a fixed shift-by-2 stage once per cycle and finishes with one shift-by-1 step when the amount is odd. A start/busy/done handshake sequences each operation, and the block sits between the ALU control decode and the writeback mux.

Parameters:
WIDTH, 32, operand/result width in bits
SHAMT_W, 5, shift-amount width; maximum shift is 2^SHAMT_W - 1

Ports:
clk      in   1        rising-edge clock
reset_n  in   1        asynchronous active-low reset
start    in   1        request; sampled only when busy=0
op       in   2        00=SLL, 01=SRL, 10=SRA, 11=reserved
operand  in   WIDTH    value to shift; captured with start
shamt    in   SHAMT_W  shift amount; captured with start
busy     out  1        high while an operation is in progress
done     out  1        one-cycle completion pulse
result   out  WIDTH    shifted value; registered and held between completions

Behaviour:
- Reset (reset_n low, asynchronous, any state): state=IDLE, busy=0, done=0, result=0, internal acc/cnt/op cleared.
  - Any in-flight operation is abandoned with no done pulse.
- The registers op_r, acc and cnt capture op, operand and shamt at accept.
- Operation is fixed at accept; later changes on op/operand/shamt have no effect.
- States: IDLE, SHIFT, DONE.
- Accept: start=1 at a rising edge while state is IDLE or DONE.
  - acc<=operand, cnt<=shamt, op_r<=op; next state SHIFT.
  - Back-to-back accept in the DONE cycle is required.
- start while busy=1 is ignored, not queued.
- SHIFT, each rising edge:
  - cnt>=2: acc shifted by 2, cnt<=cnt-2.
  - cnt==1: acc shifted by 1, cnt<=0.
  - cnt==0: no shift.
  - When the post-step cnt is 0: result<=post-step acc; next state DONE.
- Shift types: SLL zero-fills the LSBs. SRL zero-fills the MSBs. SRA replicates acc[WIDTH-1], so the sign is preserved across all steps.
- op=11: treated as shamt=0, so result=operand.
- Cycles in SHIFT: k = max(1, ceil(shamt/2)).
  - Let the accept edge be E0. result updates at edge Ek, and done=1 during the cycle after Ek.
  - Examples: shamt 0..2 gives k=1; shamt 31 gives k=16.
- busy=1 exactly in SHIFT; busy=0 in IDLE and DONE.
- done=1 exactly in DONE, for one cycle. DONE moves to IDLE, or straight to SHIFT if a new start is accepted.
- result changes only at completion or reset and is stable otherwise, including during a following operation until its completion.
- Arithmetic is pure bit shifting with no overflow flag. Bits shifted out are discarded.

Test Plan:
1. Reset, then SLL operand=0xffffffff shamt=2 -> at edge E1 result=0xfffffffc; done=1 for one cycle after E1; busy high for 1 cycle.
2. SLL 0x00000001 shamt=31 -> busy high for 16 cycles; result=0x80000000 at E16; single done pulse.
3. SRA 0xf0f0f0f0 shamt=5 -> k=3, result=0xff878787. Same operand with SRL shamt=5 -> 0x07878787.
4. SRL 0xaaaaaaaa shamt=1, plus a start pulse with operand=0 asserted while busy -> result=0x55555555; the second start is ignored; exactly one done pulse.
5. SLL 0x20000000 shamt=0 -> result=0x20000000 after k=1. In the DONE cycle, assert start with op=11, operand=0x12345678 -> accepted with no idle gap; result=0x12345678 one step later.
6. SLL 0x00000001 shamt=31, with reset_n pulsed low at E5 -> immediately busy=0, done=0, result=0; no done pulse follows. A subsequent SLL 0x3 shamt=4 completes normally with 0x00000030.
